// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Measures the high and low phase lengths (in clk cycles) of an asynchronous
// divided clock on sig_in and reports them once per full period.
// Optional duty-cycle pass flag: define DUTY_CHECK_EN to build the duty_ok port.
module div_clk_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DUTY_TOL    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             ovf
`ifdef DUTY_CHECK_EN
  ,
  output logic             duty_ok
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_range
    $error("div_clk_monitor: SYNC_STAGES must be in 2..4");
  end
  if (DUTY_TOL > (2 ** CNT_W) - 1) begin : g_tol_range
    $error("div_clk_monitor: DUTY_TOL does not fit CNT_W");
  end

  // Front end: synchronizer, delayed copy, registered edge pulses
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  logic                   sig_d_q, sig_d_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sig_s;

  // FSM, phase counters and result registers
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0]       snap_h_q, snap_h_d;
  logic [CNT_W-1:0]       snap_l_q, snap_l_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
  logic [CNT_W:0]         period_q, period_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   ovf_q, ovf_d;

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(DUTY_TOL);
  logic                   duty_q, duty_d;
  logic [CNT_W-1:0]       diff;
`endif

  // Synchronize sig_in and detect edges; vld_q marks when sig_s/sig_d hold
  // real post-reset samples, so the reset-zeroed chain never fakes an edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    sig_s   = sync_q[SYNC_STAGES-1];
    sig_d_d = sig_s;
    vld_d   = {vld_q[SYNC_STAGES-1:0], 1'b1};
    rise_d  = sig_s & ~sig_d_q & vld_q[SYNC_STAGES];
    fall_d  = ~sig_s & sig_d_q & vld_q[SYNC_STAGES];
  end

  // Phase FSM with saturating counters, snapshot on period end, output stage
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    snap_h_d     = snap_h_q;
    snap_l_d     = snap_l_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
`ifdef DUTY_CHECK_EN
    duty_d       = duty_q;
    diff         = (snap_h_q >= snap_l_q) ? (snap_h_q - snap_l_q)
                                          : (snap_l_q - snap_h_q);
`endif

    unique case (state_q)
      IDLE: begin
        if (rise_q) begin
          state_d = HIGH;
          hcnt_d  = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall_q) begin
          state_d = LOW;
          lcnt_d  = CNT_ONE;
        end else if (hcnt_q != CNT_MAX) begin
          hcnt_d = hcnt_q + CNT_ONE;
          if (hcnt_d == CNT_MAX) ovf_d = 1'b1;
        end
      end
      LOW: begin
        if (rise_q) begin
          state_d  = HIGH;
          hcnt_d   = CNT_ONE;
          snap_h_d = hcnt_q;
          snap_l_d = lcnt_q;
          done_d   = 1'b1;
        end else if (lcnt_q != CNT_MAX) begin
          lcnt_d = lcnt_q + CNT_ONE;
          if (lcnt_d == CNT_MAX) ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Results publish one cycle after the snapshot; clr drops a pending one
    if (done_q && !clr) begin
      high_cnt_d   = snap_h_q;
      low_cnt_d    = snap_l_q;
      period_d     = {1'b0, snap_h_q} + {1'b0, snap_l_q};
      meas_valid_d = 1'b1;
`ifdef DUTY_CHECK_EN
      duty_d       = ({1'b0, diff} <= TOL_W) && !ovf_q;
`endif
    end

    if (clr) begin
      state_d = IDLE;
      hcnt_d  = '0;
      lcnt_d  = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // All state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '0;
      vld_q        <= '0;
      sig_d_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      state_q      <= IDLE;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      snap_h_q     <= '0;
      snap_l_q     <= '0;
      done_q       <= 1'b0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef DUTY_CHECK_EN
      duty_q       <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      vld_q        <= vld_d;
      sig_d_q      <= sig_d_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      snap_h_q     <= snap_h_d;
      snap_l_q     <= snap_l_d;
      done_q       <= done_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      ovf_q        <= ovf_d;
`ifdef DUTY_CHECK_EN
      duty_q       <= duty_d;
`endif
    end
  end

  assign high_cnt   = high_cnt_q;
  assign low_cnt    = low_cnt_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign ovf        = ovf_q;
`ifdef DUTY_CHECK_EN
  assign duty_ok    = duty_q;
`endif

endmodule

// File: doc/div_clk_monitor.md
DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the high-time and low-time counters.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: number of synchronizer flops on sig_in.
REQ-003 Parameter DUTY_TOL, default 1: allowed |high_cnt - low_cnt| for duty_ok, in clk cycles.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 sig_in  input  1  divided clock from the upstream odd/even divider; treated as asynchronous.
REQ-007 clr  input  1  synchronous restart of measurement; clears ovf.
REQ-008 high_cnt  output  CNT_W  registered high-phase length of the last full period, in clk cycles.
REQ-009 low_cnt  output  CNT_W  registered low-phase length of the last full period, in clk cycles.
REQ-010 period  output  CNT_W+1  registered value high_cnt+low_cnt; no truncation.
REQ-011 meas_valid  output  1  one-cycle pulse when high_cnt, low_cnt and period update.
REQ-012 ovf  output  1  sticky flag set when a phase counter saturates.
REQ-013 duty_ok  output  1  registered duty-cycle pass flag (present only with DUTY_CHECK_EN).

Function
REQ-014 sig_in shall pass through SYNC_STAGES flops to give sig_s; sig_d is sig_s delayed by one cycle; rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
REQ-015 The FSM shall have three states: IDLE, HIGH, LOW; IDLE is entered from reset and from clr.
REQ-016 IDLE: on rise, go to HIGH with hcnt=1; ignore fall; no output update.
REQ-017 HIGH: each cycle without fall, hcnt increments; on fall, go to LOW with lcnt=1.
REQ-018 LOW: each cycle without rise, lcnt increments; on rise, go to HIGH with hcnt=1.
REQ-019 On the LOW->HIGH transition, the block shall register high_cnt=hcnt, low_cnt=lcnt and period=hcnt+lcnt, and pulse meas_valid high for exactly that next cycle.
REQ-020 Latency: meas_valid is asserted SYNC_STAGES+2 cycles after the first clk edge that samples sig_in high.
REQ-021 Saturation: hcnt and lcnt shall stop at 2^CNT_W-1 and not wrap; reaching the maximum sets ovf.
REQ-022 A measurement that includes a saturated phase still updates the outputs, with the saturated value.
REQ-023 ovf shall remain set until clr or reset.
REQ-024 clr shall have priority over a simultaneous rise or fall: FSM goes to IDLE, counters go to 0, ovf goes to 0, and meas_valid stays 0 that cycle.
REQ-025 clr shall not clear high_cnt, low_cnt, period or duty_ok; these hold their last values.
REQ-026 The first partial period after reset or clr shall never produce meas_valid.

Reset
REQ-027 With rst_n=0 at a clk edge, the block shall set the FSM to IDLE and all synchronizer flops, sig_d, hcnt, lcnt, high_cnt, low_cnt, period, meas_valid, ovf and duty_ok to 0.
REQ-028 Reset applied mid-measurement shall discard the partial period; no meas_valid is produced for it.

Configuration
REQ-029 Macro DUTY_CHECK_EN defined: duty_ok shall update together with meas_valid to (|high_cnt-low_cnt| <= DUTY_TOL) && !ovf, and hold between updates.
REQ-030 DUTY_CHECK_EN undefined: the duty_ok port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-031 The bench shall drive sig_in as a posedge divide-by-5 (3 cycles high, 2 low) from a 20 ns clk -> from the second rise on, each period gives high_cnt=3, low_cnt=2, period=5 and one meas_valid; duty_ok=1 with DUTY_TOL=1.
REQ-032 The bench shall drive divide-by-8 (4 high, 4 low) -> high_cnt=4, low_cnt=4, period=8, meas_valid every 8 cycles, duty_ok=1.
REQ-033 The bench shall hold sig_in high for 300 cycles with CNT_W=8, then toggle -> ovf=1, high_cnt=255 on the next update, duty_ok=0, and ovf stays 1 until clr.
REQ-034 The bench shall assert clr in the same cycle as rise during divide-by-5 -> no meas_valid that cycle, ovf=0, and the next meas_valid comes only after one full new period.
REQ-035 The bench shall pull rst_n low for 1 cycle in the middle of a high phase -> all outputs are 0 the next cycle, and the first meas_valid follows the second subsequent rise.
REQ-036 The bench shall drive a 1-cycle high glitch on sig_in between SYNC_STAGES samples -> it is either counted as a 1-cycle phase or not seen at all; the FSM must never hang, with valid pulses resuming within 2 periods.
